// File: rtl/drop_turn_ctrl.sv
// Keyboard-to-board move controller: debounced cursor moves, one-hot drop commands,
// turn alternation, full-column rejection and win/draw freeze. Optional macro: CURSOR_WRAP_EN.
module drop_turn_ctrl #(
  parameter int          NUM_COLS  = 7,
  parameter logic [7:0]  KEY_LEFT  = 8'h50,
  parameter logic [7:0]  KEY_RIGHT = 8'h4F,
  parameter logic [7:0]  KEY_DROP  = 8'h2C,
  parameter int          COL_X0    = 75,
  parameter int          COL_PITCH = 75,
  parameter int          CURSOR_Y  = 30
) (
  input  logic                frame_clk,
  input  logic                Reset_n,
  input  logic [7:0]          keycode,
  input  logic [NUM_COLS-1:0] col_full,
  input  logic                win,
  output logic [NUM_COLS-1:0] drop_red,
  output logic [NUM_COLS-1:0] drop_black,
  output logic [2:0]          cursor_col,
  output logic                turn,
  output logic                invalid,
  output logic                game_over,
  output logic                draw,
  output logic [9:0]          CursorX,
  output logic [9:0]          CursorY
);

  typedef enum logic [1:0] {IDLE, WAIT_REL, OVER} state_t;

  localparam logic [5:0]          MAX_MOVES = 6'(NUM_COLS * 6);
  localparam logic [2:0]          LAST_COL  = 3'(NUM_COLS - 1);
  localparam logic [2:0]          HOME_COL  = 3'd3;
  localparam logic [NUM_COLS-1:0] ONE_HOT0  = NUM_COLS'(1);

  state_t              state, state_n;
  logic [5:0]          move_count, move_count_n;
  logic [2:0]          col_n;
  logic                turn_n, invalid_n, game_over_n, draw_n;
  logic [NUM_COLS-1:0] drop_red_n, drop_black_n;
  logic [9:0]          cursor_x_n;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_n      = state;
    col_n        = cursor_col;
    turn_n       = turn;
    move_count_n = move_count;
    drop_red_n   = '0;
    drop_black_n = '0;
    invalid_n    = 1'b0;
    game_over_n  = game_over;
    draw_n       = draw;

    if (state != OVER) begin
      // win outranks both the draw condition and any key in the same cycle
      if (win) begin
        state_n     = OVER;
        game_over_n = 1'b1;
      end else if (move_count >= MAX_MOVES) begin
        state_n     = OVER;
        game_over_n = 1'b1;
        draw_n      = 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (keycode == KEY_LEFT) begin
              state_n = WAIT_REL;
`ifdef CURSOR_WRAP_EN
              col_n = (cursor_col == 3'd0) ? LAST_COL : cursor_col - 3'd1;
`else
              col_n = (cursor_col == 3'd0) ? 3'd0 : cursor_col - 3'd1;
`endif
            end else if (keycode == KEY_RIGHT) begin
              state_n = WAIT_REL;
`ifdef CURSOR_WRAP_EN
              col_n = (cursor_col == LAST_COL) ? 3'd0 : cursor_col + 3'd1;
`else
              col_n = (cursor_col == LAST_COL) ? LAST_COL : cursor_col + 3'd1;
`endif
            end else if (keycode == KEY_DROP) begin
              state_n = WAIT_REL;
              if (!col_full[cursor_col]) begin
                if (turn) drop_black_n = ONE_HOT0 << cursor_col;
                else      drop_red_n   = ONE_HOT0 << cursor_col;
                turn_n       = ~turn;
                move_count_n = (move_count == MAX_MOVES) ? move_count : move_count + 6'd1;
              end else begin
                invalid_n = 1'b1;
              end
            end
          end
          WAIT_REL: if (keycode == 8'h00) state_n = IDLE;
          default:  state_n = IDLE;
        endcase
      end
    end
  end

  assign cursor_x_n = 10'(COL_X0 + COL_PITCH * int'(col_n));

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      cursor_col <= HOME_COL;
      turn       <= 1'b0;
      move_count <= '0;
      drop_red   <= '0;
      drop_black <= '0;
      invalid    <= 1'b0;
      game_over  <= 1'b0;
      draw       <= 1'b0;
      CursorX    <= 10'(COL_X0 + COL_PITCH * 3);
      CursorY    <= 10'(CURSOR_Y);
    end else begin
      state      <= state_n;
      cursor_col <= col_n;
      turn       <= turn_n;
      move_count <= move_count_n;
      drop_red   <= drop_red_n;
      drop_black <= drop_black_n;
      invalid    <= invalid_n;
      game_over  <= game_over_n;
      draw       <= draw_n;
      CursorX    <= cursor_x_n;
      CursorY    <= 10'(CURSOR_Y);
    end
  end

endmodule

// File: tb/tb_drop_turn_ctrl.sv
// Directed self-checking bench for drop_turn_ctrl; honours CURSOR_WRAP_EN if defined.
module tb_drop_turn_ctrl;

  localparam logic [7:0] K_LEFT  = 8'h50;
  localparam logic [7:0] K_RIGHT = 8'h4F;
  localparam logic [7:0] K_DROP  = 8'h2C;

  logic       frame_clk;
  logic       Reset_n;
  logic [7:0] keycode;
  logic [6:0] col_full;
  logic       win;
  logic [6:0] drop_red, drop_black;
  logic [2:0] cursor_col;
  logic       turn, invalid, game_over, draw;
  logic [9:0] CursorX, CursorY;

  int checks = 0;
  int errors = 0;

  drop_turn_ctrl dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .keycode   (keycode),
    .col_full  (col_full),
    .win       (win),
    .drop_red  (drop_red),
    .drop_black(drop_black),
    .cursor_col(cursor_col),
    .turn      (turn),
    .invalid   (invalid),
    .game_over (game_over),
    .draw      (draw),
    .CursorX   (CursorX),
    .CursorY   (CursorY)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    tick();
  endtask

  task automatic release_key();
    keycode = 8'h00;
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_drop_red"},   32'(drop_red),   32'h0);
    check({tag, "_drop_black"}, 32'(drop_black), 32'h0);
    check({tag, "_invalid"},    32'(invalid),    32'h0);
  endtask

  initial begin
    int         exp_col;
    bit         dir_right;
    logic [6:0] exp_oh;

    Reset_n  = 1'b1;
    keycode  = 8'h00;
    col_full = '0;
    win      = 1'b0;
    #1 Reset_n = 1'b0;
    #2;
    check("rst_cursor_col", 32'(cursor_col), 32'd3);
    check("rst_cursor_x",   32'(CursorX),    32'd300);
    check("rst_cursor_y",   32'(CursorY),    32'd30);
    check("rst_turn",       32'(turn),       32'd0);
    check("rst_game_over",  32'(game_over),  32'd0);
    check("rst_draw",       32'(draw),       32'd0);
    check_idle_outputs("rst");

    tick();
    Reset_n = 1'b1;
    repeat (5) tick();
    check("idle_cursor_col", 32'(cursor_col), 32'd3);
    check("idle_cursor_x",   32'(CursorX),    32'd300);
    check("idle_turn",       32'(turn),       32'd0);
    check_idle_outputs("idle");

    // First drop held for three cycles: exactly one red pulse.
    press(K_DROP);
    check("drop1_red",   32'(drop_red),   32'h08);
    check("drop1_black", 32'(drop_black), 32'h00);
    check("drop1_turn",  32'(turn),       32'd1);
    tick();
    check("drop1_held_red", 32'(drop_red), 32'h00);
    tick();
    check("drop1_held2_red", 32'(drop_red), 32'h00);
    release_key();
    check_idle_outputs("drop1_rel");

    press(K_DROP);
    check("drop2_black", 32'(drop_black), 32'h08);
    check("drop2_red",   32'(drop_red),   32'h00);
    check("drop2_turn",  32'(turn),       32'd0);
    release_key();
    check("drop2_rel_black", 32'(drop_black), 32'h00);

    // Four LEFT presses: 2,1,0 then saturate at 0 (or wrap to 6).
    press(K_LEFT); check("left1_col", 32'(cursor_col), 32'd2); check("left1_x", 32'(CursorX), 32'd225); release_key();
    press(K_LEFT); check("left2_col", 32'(cursor_col), 32'd1); check("left2_x", 32'(CursorX), 32'd150); release_key();
    press(K_LEFT); check("left3_col", 32'(cursor_col), 32'd0); check("left3_x", 32'(CursorX), 32'd75);  release_key();
    press(K_LEFT);
`ifdef CURSOR_WRAP_EN
    check("left4_col", 32'(cursor_col), 32'd6); check("left4_x", 32'(CursorX), 32'd525);
    release_key();
    press(K_RIGHT); check("right_wrap_col", 32'(cursor_col), 32'd0); check("right_wrap_x", 32'(CursorX), 32'd75);
`else
    check("left4_col", 32'(cursor_col), 32'd0); check("left4_x", 32'(CursorX), 32'd75);
    check("left4_turn", 32'(turn), 32'd0);
`endif
    release_key();
    press(K_RIGHT); check("right1_col", 32'(cursor_col), 32'd1); check("right1_x", 32'(CursorX), 32'd150); release_key();
    press(K_RIGHT); check("right2_col", 32'(cursor_col), 32'd2); check("right2_x", 32'(CursorX), 32'd225); release_key();
    press(K_RIGHT); check("right3_col", 32'(cursor_col), 32'd3); check("right3_x", 32'(CursorX), 32'd300); release_key();

    // Drop into a full column is rejected.
    col_full = 7'b0001000;
    press(K_DROP);
    check("full_invalid", 32'(invalid),    32'd1);
    check("full_red",     32'(drop_red),   32'h00);
    check("full_black",   32'(drop_black), 32'h00);
    check("full_turn",    32'(turn),       32'd0);
    release_key();
    check("full_invalid_rel", 32'(invalid), 32'd0);
    col_full = '0;

    // Remaining 40 drops (moves 2..41) sweep the cursor back and forth.
    exp_col   = 3;
    dir_right = 1'b1;
    for (int m = 2; m < 42; m++) begin
      press(K_DROP);
      exp_oh = 7'b0000001 << exp_col;
      if (m % 2 == 0) begin
        check("fill_red",   32'(drop_red),   32'(exp_oh));
        check("fill_black", 32'(drop_black), 32'h00);
      end else begin
        check("fill_black", 32'(drop_black), 32'(exp_oh));
        check("fill_red",   32'(drop_red),   32'h00);
      end
      release_key();
      if (m < 41) begin
        if (dir_right && exp_col == 6)      dir_right = 1'b0;
        else if (!dir_right && exp_col == 0) dir_right = 1'b1;
        press(dir_right ? K_RIGHT : K_LEFT);
        exp_col = dir_right ? exp_col + 1 : exp_col - 1;
        release_key();
      end
    end
    check("draw_flag",      32'(draw),       32'd1);
    check("draw_game_over", 32'(game_over),  32'd1);
    check("draw_cursor",    32'(cursor_col), 32'(exp_col));

    press(K_DROP);
    check_idle_outputs("after_draw");
    release_key();
    press(K_LEFT);
    check("after_draw_cursor", 32'(cursor_col), 32'(exp_col));
    release_key();

    // Reset clears the frozen game.
    Reset_n = 1'b0;
    #1;
    check("rst2_game_over", 32'(game_over),  32'd0);
    check("rst2_draw",      32'(draw),       32'd0);
    check("rst2_cursor",    32'(cursor_col), 32'd3);
    tick();
    Reset_n = 1'b1;

    // win in the same cycle as a drop: no drop, game over.
    keycode = K_DROP;
    win     = 1'b1;
    tick();
    check("win_red",       32'(drop_red),   32'h00);
    check("win_black",     32'(drop_black), 32'h00);
    check("win_game_over", 32'(game_over),  32'd1);
    check("win_draw",      32'(draw),       32'd0);
    check("win_turn",      32'(turn),       32'd0);
    win = 1'b0;
    release_key();
    press(K_DROP);
    check_idle_outputs("after_win");
    release_key();
    press(K_RIGHT);
    check("after_win_cursor", 32'(cursor_col), 32'd3);
    check("after_win_over",   32'(game_over),  32'd1);
    release_key();

    // Key held across reset release acts exactly once.
    keycode = K_DROP;
    Reset_n = 1'b0;
    #1;
    check("rst3_game_over", 32'(game_over), 32'd0);
    tick();
    Reset_n = 1'b1;
    tick();
    check("held_rst_red", 32'(drop_red), 32'h08);
    tick();
    check("held_rst_red_once", 32'(drop_red), 32'h00);
    check("held_rst_turn",     32'(turn),     32'd1);
    release_key();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
